// File: rtl/speck32_iter_core_if.sv
// Block/key request and ciphertext response channels of the iterative SPECK 32/64 core.
// The master side drives plaintext and key and consumes the ciphertext.
interface speck32_iter_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_left;
    logic [15:0] out_right;

    modport master (
        output in_valid, in_data, key, out_ready,
        input  in_ready, out_valid, out_left, out_right
    );

    modport slave (
        input  in_valid, in_data, key, out_ready,
        output in_ready, out_valid, out_left, out_right
    );
endinterface

// File: rtl/speck32_iter_core.sv
// Iterative SPECK 32/64 encryption core: one round per clock, with the key schedule
// computed alongside the data round.
module speck32_iter_core #(
    parameter int ROUNDS = 22,
    parameter int ALPHA  = 7,
    parameter int BETA   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    speck32_iter_core_if.slave  bus,
    output logic                busy,
    output logic [4:0]          round_idx,
    output logic [15:0]         debug_key
);

    if (ROUNDS < 1 || ROUNDS > 22) begin : g_bad_rounds
        $error("speck32_iter_core: ROUNDS must be in 1..22");
    end
    if (ALPHA < 0 || ALPHA > 15 || BETA < 0 || BETA > 15) begin : g_bad_rot
        $error("speck32_iter_core: ALPHA and BETA must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    state_t      state;
    logic [15:0] x, y, k, l0, l1, l2;
    logic [4:0]  i;
    logic        in_ready_q, out_valid_q;
    logic [15:0] out_left_q, out_right_q;

    logic [15:0] x_nxt, y_nxt, l_nxt, k_nxt;

    // Data round and key-schedule round share the same ARX shape and run in parallel.
    assign x_nxt = (ror16(x, ALPHA) + y) ^ k;
    assign y_nxt = rol16(y, BETA) ^ x_nxt;
    assign l_nxt = (k + ror16(l0, ALPHA)) ^ {11'd0, i};
    assign k_nxt = rol16(k, BETA) ^ l_nxt;

    // NOTE: every register here, including the datapath words, sits on the async
    // reset so that a mid-run reset discards the in-flight block completely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            k           <= '0;
            l0          <= '0;
            l1          <= '0;
            l2          <= '0;
            i           <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every round reading the pre-edge
            // values of x, y, k and l0..l2, regardless of statement order.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x          <= bus.in_data[31:16];
                        y          <= bus.in_data[15:0];
                        k          <= bus.key[15:0];
                        l0         <= bus.key[31:16];
                        l1         <= bus.key[47:32];
                        l2         <= bus.key[63:48];
                        i          <= '0;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    x  <= x_nxt;
                    y  <= y_nxt;
                    l0 <= l1;
                    l1 <= l2;
                    l2 <= l_nxt;
                    if (i == LAST) begin
                        // k and i are zeroed on exit so round_idx/debug_key read 0 outside RUN.
                        k           <= '0;
                        i           <= '0;
                        out_left_q  <= x_nxt;
                        out_right_q <= y_nxt;
                        out_valid_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        k <= k_nxt;
                        i <= i + 5'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_left  = out_left_q;
    assign bus.out_right = out_right_q;
    assign round_idx     = i;
    assign debug_key     = k;

endmodule

// File: tb/tb_speck32_iter_core.sv
// Scoreboard bench for speck32_iter_core: a 22-round instance for the published vector
// and handshake cases, and a 1-round instance for hand-computed single-round results.
module tb_speck32_iter_core;

    localparam logic [63:0] VEC_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] VEC_PT  = 32'h6574_694c;
    localparam logic [15:0] VEC_L   = 16'ha868;
    localparam logic [15:0] VEC_R   = 16'h42f2;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    speck32_iter_core_if u_if ();
    speck32_iter_core_if u_if1 ();

    logic        busy0, busy1;
    logic [4:0]  ridx0, ridx1;
    logic [15:0] dkey0, dkey1;

    speck32_iter_core #(.ROUNDS(22)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(u_if),
        .busy(busy0), .round_idx(ridx0), .debug_key(dkey0)
    );

    speck32_iter_core #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u_if1),
        .busy(busy1), .round_idx(ridx1), .debug_key(dkey1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    int   rises0[$];
    int   rises1[$];
    int   n_acc0 = 0;
    int   n_acc1 = 0;
    logic [15:0] exp0_l, exp0_r, exp1_l, exp1_r;
    logic pv0 = 1'b0;
    logic pv1 = 1'b0;
    exp_t e0, e1, p0, p1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Accept monitors: the expected response for the stimulus on the bus goes into the queue.
    always @(negedge clk) begin
        if (rst_n && u_if.in_valid && u_if.in_ready) begin
            p0.l = exp0_l; p0.r = exp0_r; p0.acc = cyc + 1;
            sb0.push_back(p0);
            n_acc0++;
        end
        if (rst_n && u_if1.in_valid && u_if1.in_ready) begin
            p1.l = exp1_l; p1.r = exp1_r; p1.acc = cyc + 1;
            sb1.push_back(p1);
            n_acc1++;
        end
    end

    // Output monitors: latency on the rising edge of out_valid, data on the handshake.
    always @(negedge clk) begin
        if (rst_n && u_if.out_valid && !pv0) begin
            rises0.push_back(cyc);
            if (sb0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut22 out_valid with empty scoreboard at cycle %0d", cyc);
            end else check("dut22 latency", cyc - sb0[0].acc, 22);
        end
        if (rst_n && u_if.out_valid && u_if.out_ready && sb0.size() > 0) begin
            e0 = sb0.pop_front();
            check("dut22 out_left", {16'd0, u_if.out_left}, {16'd0, e0.l});
            check("dut22 out_right", {16'd0, u_if.out_right}, {16'd0, e0.r});
        end
        pv0 = u_if.out_valid;

        if (rst_n && u_if1.out_valid && !pv1) begin
            rises1.push_back(cyc);
            if (sb1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1 out_valid with empty scoreboard at cycle %0d", cyc);
            end else check("dut1 latency", cyc - sb1[0].acc, 1);
        end
        if (rst_n && u_if1.out_valid && u_if1.out_ready && sb1.size() > 0) begin
            e1 = sb1.pop_front();
            check("dut1 out_left", {16'd0, u_if1.out_left}, {16'd0, e1.l});
            check("dut1 out_right", {16'd0, u_if1.out_right}, {16'd0, e1.r});
        end
        pv1 = u_if1.out_valid;
    end

    task automatic send(input int which, input logic [31:0] d, input logic [63:0] k,
                        input logic [15:0] el, input logic [15:0] er);
        int n = 0;
        @(posedge clk); #1;
        if (which == 0) begin
            u_if.in_valid = 1'b1; u_if.in_data = d; u_if.key = k; exp0_l = el; exp0_r = er;
        end else begin
            u_if1.in_valid = 1'b1; u_if1.in_data = d; u_if1.key = k; exp1_l = el; exp1_r = er;
        end
        while (!(which == 0 ? u_if.in_ready : u_if1.in_ready) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) timeout("send in_ready");
        @(posedge clk); #1;
        if (which == 0) u_if.in_valid = 1'b0;
        else u_if1.in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int n = 0;
        while ((which == 0 ? sb0.size() : sb1.size()) > 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) timeout("drain scoreboard");
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"}, {31'd0, u_if.in_ready}, 1);
        check({tag, " out_valid"}, {31'd0, u_if.out_valid}, 0);
        check({tag, " busy"}, {31'd0, busy0}, 0);
        check({tag, " out_left"}, {16'd0, u_if.out_left}, 0);
        check({tag, " out_right"}, {16'd0, u_if.out_right}, 0);
        check({tag, " round_idx"}, {27'd0, ridx0}, 0);
        check({tag, " debug_key"}, {16'd0, dkey0}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        u_if.in_valid = 1'b0;  u_if.in_data = '0;  u_if.key = '0;  u_if.out_ready = 1'b1;
        u_if1.in_valid = 1'b0; u_if1.in_data = '0; u_if1.key = '0; u_if1.out_ready = 1'b1;
        exp0_l = '0; exp0_r = '0; exp1_l = '0; exp1_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        // Published vector; round 0 must use k0.
        send(0, VEC_PT, VEC_KEY, VEC_L, VEC_R);
        check("round0 busy", {31'd0, busy0}, 1);
        check("round0 round_idx", {27'd0, ridx0}, 0);
        check("round0 debug_key", {16'd0, dkey0}, 32'h0100);
        check("round0 in_ready", {31'd0, u_if.in_ready}, 0);
        drain(0);

        // Back-pressure: the result must hold while out_ready is low.
        u_if.out_ready = 1'b0;
        send(0, VEC_PT, VEC_KEY, VEC_L, VEC_R);
        n = 0;
        while (!u_if.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("backpressure out_valid");
        repeat (10) begin
            @(posedge clk); #1;
            check("hold out_left", {16'd0, u_if.out_left}, {16'd0, VEC_L});
            check("hold out_right", {16'd0, u_if.out_right}, {16'd0, VEC_R});
            check("hold in_ready", {31'd0, u_if.in_ready}, 0);
            check("hold out_valid", {31'd0, u_if.out_valid}, 1);
        end
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", {31'd0, u_if.in_ready}, 1);
        check("release out_valid", {31'd0, u_if.out_valid}, 0);
        drain(0);

        // in_valid with garbage while busy must be ignored.
        base = rises0.size();
        send(0, VEC_PT, VEC_KEY, VEC_L, VEC_R);
        u_if.in_valid = 1'b1; u_if.in_data = 32'hffff_ffff; exp0_l = '0; exp0_r = '0;
        repeat (18) @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        drain(0);
        repeat (30) @(posedge clk);
        check("ignore-busy pulse count", rises0.size() - base, 1);

        // Asynchronous reset in the middle of the run.
        send(0, VEC_PT, VEC_KEY, VEC_L, VEC_R);
        n = 0;
        while (ridx0 != 5'd11 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("wait round_idx 11");
        @(negedge clk); #2;
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        #1;
        check_reset_vals("midrun reset");
        @(negedge clk) rst_n = 1'b1;
        send(0, VEC_PT, VEC_KEY, VEC_L, VEC_R);
        drain(0);

        // Back-to-back with in_valid held: one result per ROUNDS+2 cycles.
        base = rises0.size();
        n = n_acc0;
        @(posedge clk); #1;
        u_if.in_valid = 1'b1; u_if.in_data = VEC_PT; u_if.key = VEC_KEY;
        exp0_l = VEC_L; exp0_r = VEC_R;
        begin
            int w = 0;
            while (n_acc0 < n + 3 && w < 200) begin @(posedge clk); w++; end
            if (w >= 200) timeout("back-to-back accepts");
        end
        #1;
        u_if.in_valid = 1'b0;
        drain(0);
        check("b2b pulse count", rises0.size() - base, 3);
        if (rises0.size() >= base + 3) begin
            check("b2b spacing 1", rises0[base + 1] - rises0[base], 24);
            check("b2b spacing 2", rises0[base + 2] - rises0[base + 1], 24);
        end

        // Single-round instance.
        send(1, 32'h0000_0000, 64'd0, 16'h0000, 16'h0000);
        drain(1);
        send(1, 32'h0001_0000, 64'd0, 16'h0200, 16'h0200);
        drain(1);
        check("dut1 pulse count", rises1.size(), 2);

        check("dut22 scoreboard empty", sb0.size(), 0);
        check("dut1 scoreboard empty", sb1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/speck32_iter_core.md
Name: speck32_iter_core

Overview:
Iterative SPECK 32/64 encryption engine with an on-the-fly key schedule. It executes one round per clock and sits directly downstream of the plaintext source, wrapping the same round arithmetic as the combinational SPECKEY round. It takes a 32-bit block plus a 64-bit key through a valid/ready handshake. After ROUNDS cycles it presents the ciphertext as left/right 16-bit words, held until consumed.

Parameters:
ROUNDS, 22, number of rounds executed; legal range 1..22 (22 = full SPECK 32/64)
ALPHA, 7, right-rotate amount applied to the left word and to key word l
BETA, 2, left-rotate amount applied to the right word and to key word k

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  block and key present on in_data/key
in_ready  output  1  core can accept a new block
in_data  input  32  plaintext; [31:16] = x (left), [15:0] = y (right)
key  input  64  key words {l2, l1, l0, k0}: l2 = [63:48], l1 = [47:32], l0 = [31:16], k0 = [15:0]
out_valid  output  1  ciphertext valid
out_ready  input  1  consumer accepts ciphertext
out_left  output  16  ciphertext x
out_right  output  16  ciphertext y
busy  output  1  rounds in progress
round_idx  output  5  index of the round executed at the next edge; 0 when idle
debug_key  output  16  round key k_i used at the next edge

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, out_left=0, out_right=0, round_idx=0, debug_key=0. All internal x, y, k, l0..l2 and counter registers clear to 0.
- in_ready = (state==IDLE). busy = (state==RUN). out_valid = (state==DONE).
- Accept: on an edge where in_valid && in_ready:
  - Load x, y from in_data.
  - Load k=k0, l0, l1, l2 from key.
  - Set i=0 and go to RUN.
  - in_data and key are sampled only at this edge.
- RUN, each edge, for round i:
  - x' = (ROR(x,ALPHA) + y) mod 2^16 XOR k
  - y' = ROL(y,BETA) XOR x'
  - lnew = (k + ROR(l0,ALPHA)) mod 2^16 XOR i (i zero-extended to 16 bits)
  - k' = ROL(k,BETA) XOR lnew
  - l0<=l1, l1<=l2, l2<=lnew, i<=i+1
- Round-key schedule: round 0 uses k0; the key update is computed in parallel, so there are no extra cycles. Additions are 16-bit modular and carries are discarded.
- RUN ends: when i==ROUNDS-1 the state goes to DONE at that edge.
- Latency: an accept at edge T produces out_valid high after edge T+ROUNDS (22 cycles for the default). in_ready is low from T+1 until DONE exits.
- DONE: out_left/out_right equal the final x/y and stay stable while out_valid && !out_ready.
  - On an edge with out_ready=1 the state returns to IDLE and in_ready rises after that edge.
  - There is no same-cycle reuse, so the back-to-back throughput is one block per ROUNDS+2 cycles with out_ready tied high.
- in_valid while not IDLE is ignored. No capture happens and the in-flight block is not corrupted.
- out_left/out_right update only on the RUN→DONE edge and otherwise hold their last value.
- Asserting rst_n low mid-RUN or in DONE immediately (asynchronously) returns all outputs to their reset values. The in-flight block is discarded.
- round_idx = i during RUN, 0 otherwise. debug_key = k during RUN, 0 otherwise.
- ROUNDS outside 1..22 is illegal and is flagged by a simulation-only check at elaboration.

Test Plan:
1. Published vector: key=64'h1918_1110_0908_0100, in_data=32'h6574_694c, out_ready=1 → out_valid exactly 22 cycles after accept, out_left=16'ha868, out_right=16'h42f2; debug_key in round 0 = 16'h0100.
2. Back-pressure: same vector with out_ready=0 for 10 cycles after out_valid → out_left/out_right stay a868/42f2, in_ready stays 0; out_ready=1 → IDLE next cycle, in_ready=1.
3. Ignore-while-busy: accept vector 1, then drive in_valid=1 with in_data=32'hffff_ffff at cycles 3..21 → result is still a868/42f2 and only one out_valid pulse occurs.
4. Reset mid-operation: drop rst_n at round_idx=11 → outputs are at reset values immediately. Reapply vector 1 after release → a868/42f2 after 22 cycles.
5. Back-to-back: in_valid held high with vector 1 repeated, out_ready=1 → out_valid pulses every 24 cycles, each result a868/42f2.
6. Reduced rounds: ROUNDS=1, key=0, in_data=0 → out_valid 1 cycle after accept, out_left=0, out_right=0. Then in_data=32'h0001_0000 → out_left=16'h0200, out_right=16'h0200.
